// File: rtl/div_pkg.sv
// Shared constants and FSM encoding for the div16 restoring divider.
// No ports: imported by div16.
package div_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int ITERATIONS = 16;
  localparam int CNT_W      = $clog2(ITERATIONS);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
// Ports: a, b, cin -> s, cout.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/sub9.sv
// 9-bit ripple subtractor d = a - b built from full_adder cells.
// Ports: a, b -> d, borrow (borrow=0 means a >= b).
module sub9 (
  input  logic [8:0] a,
  input  logic [8:0] b,
  output logic [8:0] d,
  output logic       borrow
);

  logic [9:0] c;

  // a + ~b + 1; carry out set means no borrow
  assign c[0] = 1'b1;

  for (genvar i = 0; i < 9; i++) begin : gen_fa
    full_adder u_fa (
      .a   (a[i]),
      .b   (~b[i]),
      .cin (c[i]),
      .s   (d[i]),
      .cout(c[i+1])
    );
  end

  assign borrow = ~c[9];

endmodule

// File: rtl/div16.sv
// 16/8 unsigned restoring divider, one quotient bit per clock, MSB first.
// Ports: clk, rst_n, A, B, start -> Q, R, busy, done, div_zero.
module div16
  import div_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIVIDEND_W-1:0] A,
  input  logic [DIVISOR_W-1:0]  B,
  input  logic                  start,
  output logic [DIVIDEND_W-1:0] Q,
  output logic [DIVISOR_W-1:0]  R,
  output logic                  busy,
  output logic                  done,
  output logic                  div_zero
);

  state_t state, state_nx;

  logic [DIVIDEND_W-1:0] dq;
  logic [DIVISOR_W-1:0]  bq;
  logic [DIVISOR_W:0]    p;
  logic [CNT_W-1:0]      cnt;

  logic [DIVISOR_W:0] t;
  logic [DIVISOR_W:0] diff;
  logic [DIVISOR_W:0] p_nx;
  logic               borrow;
  logic               qbit;
  logic               accept;
  logic               last;
  logic               zdiv;

  assign accept = start && (state != RUN);
  assign last   = (cnt == CNT_W'(ITERATIONS - 1));
  assign zdiv   = (bq == '0);

  // dq shifts dividend bits out of the top and quotient bits in at the bottom
  assign t    = {p[DIVISOR_W-1:0], dq[DIVIDEND_W-1]};
  assign qbit = ~borrow;
  assign p_nx = borrow ? t : diff;

  sub9 u_sub (
    .a     (t),
    .b     ({1'b0, bq}),
    .d     (diff),
    .borrow(borrow)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = RUN;
      RUN:  if (zdiv || last) state_nx = DONE;
      DONE: state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Q        <= '0;
      R        <= '0;
      div_zero <= 1'b0;
      dq       <= '0;
      bq       <= '0;
      p        <= '0;
      cnt      <= '0;
    end else if (accept) begin
      dq  <= A;
      bq  <= B;
      p   <= '0;
      cnt <= '0;
      if (B != '0) div_zero <= 1'b0;
    end else if (state == RUN) begin
      if (zdiv) begin
        // no iterations: dq still holds the untouched dividend
        Q        <= '1;
        R        <= dq[DIVISOR_W-1:0];
        div_zero <= 1'b1;
      end else begin
        p   <= p_nx;
        dq  <= {dq[DIVIDEND_W-2:0], qbit};
        cnt <= cnt + 1'b1;
        if (last) begin
          Q <= {dq[DIVIDEND_W-2:0], qbit};
          R <= p_nx[DIVISOR_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_div16.sv
// Directed and random self-checking bench for div16.
// Drives A/B/start #1 after the rising edge and samples there too.
module tb_div16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] A = '0;
  logic [7:0]  B = '0;
  logic [15:0] Q;
  logic [7:0]  R;
  logic        busy;
  logic        done;
  logic        div_zero;

  int errs = 0;
  int nchk = 0;

  div16 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .A       (A),
    .B       (B),
    .start   (start),
    .Q       (Q),
    .R       (R),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [15:0] a, input logic [7:0] b);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(inout int n);
    while (!done && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
  endtask

  task automatic op(input string tag, input logic [15:0] a,
                    input logic [7:0] b, input logic [15:0] eq,
                    input logic [7:0] er, input logic edz,
                    input int elat);
    int n;
    n = 0;
    launch(a, b);
    wait_done(n);
    chk({tag, "_lat"}, n, elat);
    chk({tag, "_q"}, Q, eq);
    chk({tag, "_r"}, R, er);
    chk({tag, "_dz"}, div_zero, edz);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int n;
    int nd;
    logic [15:0] a;
    logic [7:0]  b;

    // reset with start asserted: reset must win
    start = 1'b1;
    A = 16'h1234;
    B = 8'h05;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", Q, 0);
    chk("rst_r", R, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_zero, 0);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    op("d1000_7", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 16);
    @(posedge clk);
    #1;
    chk("pulse_low", done, 0);
    chk("hold_q", Q, 16'd142);
    chk("hold_r", R, 8'd6);

    op("ffff_1", 16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0, 16);
    op("ffff_ff", 16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 16);
    op("dzero", 16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1, 1);
    op("d10_3", 16'd10, 8'd3, 16'd3, 8'd1, 1'b0, 16);

    // start pulsed mid-run with new operands must be ignored
    n = 0;
    launch(16'd500, 8'd9);
    repeat (5) begin
      @(posedge clk);
      #1 n++;
    end
    A = 16'hFFFF;
    B = 8'h01;
    start = 1'b1;
    @(posedge clk);
    #1 n++;
    start = 1'b0;
    chk("ign_busy", busy, 1);
    wait_done(n);
    chk("ign_lat", n, 16);
    chk("ign_q", Q, 16'd55);
    chk("ign_r", R, 8'd5);

    // reset mid-run aborts without a done pulse
    op("d100_3", 16'd100, 8'd3, 16'd33, 8'd1, 1'b0, 16);
    launch(16'd200, 8'd7);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_q", Q, 0);
    chk("abort_r", R, 0);
    chk("abort_done", done, 0);
    rst_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (done) nd++;
    end
    chk("abort_nodone", nd, 0);

    // back-to-back random operations, relaunched in the done cycle
    for (int i = 0; i < 2000; i++) begin
      a = 16'($urandom);
      b = 8'($urandom_range(1, 255));
      n = 0;
      launch(a, b);
      wait_done(n);
      chk($sformatf("rnd%0d_lat", i), n, 16);
      chk($sformatf("rnd%0d_q", i), Q, a / 16'(b));
      chk($sformatf("rnd%0d_r", i), R, 8'(a % 16'(b)));
      chk($sformatf("rnd%0d_id", i), 32'(Q) * 32'(b) + 32'(R), 32'(a));
      chk($sformatf("rnd%0d_rlt", i), 32'(R < b), 1);
    end

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
